// File: rtl/note_glyph_renderer_if.sv
// note_glyph_renderer_if: row stream from the glyph renderer to the frame-buffer writer.
interface note_glyph_renderer_if;
    logic        row_valid;
    logic        row_ready;
    logic [23:0] row_data;
    logic [5:0]  row_addr;
    modport master(output row_valid, row_data, row_addr, input row_ready);
    modport slave(input row_valid, row_data, row_addr, output row_ready);
endinterface

// File: rtl/note_glyph_renderer.sv
// note_glyph_renderer: streams a 64x24 glyph region for one note/length code pair.
// Optional ledger line through the k=0 head is enabled by defining RENDER_LEDGER_EN.
module note_glyph_renderer #(
    parameter int HEAD_LSB = 10,
    parameter int STEM_COL = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [15:0]                   note_code,
    input  logic [15:0]                   length_code,
    note_glyph_renderer_if.master         rowBus,
    output logic                          busy,
    output logic                          done,
    output logic                          code_err
);
    typedef enum logic [1:0] {IDLE, EMIT, DONE} stateT;
    stateT       state, nextState;
    logic [5:0]  cnt;
    logic [2:0]  kReg, decK, gK;
    logic        shortReg, okReg, decShort, decOk, gShort, gOk, xfer, accept;
    logic [6:0]  gRow, base, off;
    logic [3:0]  head;
    logic [23:0] rowData, glyph;

    assign xfer = rowBus.row_valid && rowBus.row_ready;
    assign accept = (state == IDLE) && start;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign rowBus.row_valid = state == EMIT;
    assign rowBus.row_addr = cnt;
    assign rowBus.row_data = rowData;

    always_comb begin
        decShort = length_code == 16'h0001;
        decK = (note_code == 16'h0001) ? 3'd6 : note_code[2:0] - 3'd2;
        decOk = ((note_code[15:4] == 12'h000 && note_code[3:0] >= 4'hA) || note_code == 16'h0001)
                && (decShort || length_code == 16'h0010);
    end

    // The glyph for the next row to present: row 0 of the new codes at accept, else cnt+1.
    always_comb begin
        gRow = (state == IDLE) ? 7'd0 : {1'b0, cnt} + 7'd1;
        gK = (state == IDLE) ? decK : kReg;
        gShort = (state == IDLE) ? decShort : shortReg;
        gOk = (state == IDLE) ? decOk : okReg;
        base = {1'b0, gK, 3'b000};
        off = gRow - base;
        head = (off[2:0] == 3'd0 || off[2:0] == 3'd7) ? 4'b0110 : gShort ? 4'b1111 : 4'b1001;
        glyph = '0;
        if (gOk && off < 7'd8) glyph[HEAD_LSB +: 4] = head;
        if (gOk && gShort && off >= 7'd8 && off < 7'd16) glyph[STEM_COL] = 1'b1;
`ifdef RENDER_LEDGER_EN
        if (gOk && gK == 3'd0 && gRow == 7'd3) glyph[HEAD_LSB - 2 +: 8] = 8'hFF;
`endif
    end

    always_comb begin
        nextState = state;
        nextState = accept ? EMIT :
                    (state == EMIT && xfer && cnt == 6'd63) ? DONE :
                    (state == DONE) ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= nextState;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            rowData <= '0;
            kReg <= '0;
            shortReg <= 1'b0;
            okReg <= 1'b0;
            code_err <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            rowData <= glyph;
            kReg <= decK;
            shortReg <= decShort;
            okReg <= decOk;
            code_err <= !decOk;
        end else if (xfer && cnt != 6'd63) begin
            cnt <= cnt + 6'd1;
            rowData <= glyph;
        end
    end
endmodule

// File: tb/tb_note_glyph_renderer.sv
// tb_note_glyph_renderer: random and directed frames checked every cycle against a spec-level model.
`timescale 1ns/1ps
module tb_note_glyph_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] note_code = '0;
    logic [15:0] length_code = '0;
    logic        busy, done, code_err;
    int          checks = 0;
    int          errors = 0;
    int          doneCnt = 0;
    int          mPhase = 0;
    int          mRow = 0;
    logic [15:0] mNote = '0;
    logic [15:0] mLen = '0;
    logic        mErr = 1'b0;
    logic [23:0] cap [64];

    note_glyph_renderer_if rowBus();

    note_glyph_renderer dut (
        .clk(clk), .rst(rst), .start(start), .note_code(note_code), .length_code(length_code),
        .rowBus(rowBus), .busy(busy), .done(done), .code_err(code_err)
    );

    always #5 clk = ~clk;

    function automatic int noteIdx(input logic [15:0] n);
        if (n >= 16'h000A && n <= 16'h000F) return int'(n) - 10;
        if (n == 16'h0001) return 6;
        return -1;
    endfunction

    function automatic bit codesOk(input logic [15:0] n, input logic [15:0] l);
        return noteIdx(n) >= 0 && (l == 16'h0001 || l == 16'h0010);
    endfunction

    function automatic logic [23:0] expRow(input logic [15:0] n, input logic [15:0] l, input int row);
        logic [23:0] r;
        int o;
        r = '0;
        if (!codesOk(n, l)) return r;
        o = row - 8 * noteIdx(n);
        if (o >= 0 && o < 8) r[13:10] = (o == 0 || o == 7) ? 4'b0110 : (l == 16'h0001) ? 4'b1111 : 4'b1001;
        else if (l == 16'h0001 && o >= 8 && o < 16) r[14] = 1'b1;
`ifdef RENDER_LEDGER_EN
        if (noteIdx(n) == 0 && row == 3) r = r | 24'h00FF00;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mPhase = 0;
            mRow = 0;
            mErr = 1'b0;
        end else if (mPhase == 0) begin
            if (start) begin
                mNote = note_code;
                mLen = length_code;
                mErr = !codesOk(note_code, length_code);
                mRow = 0;
                mPhase = 1;
            end
        end else if (mPhase == 1) begin
            if (rowBus.row_ready) begin
                if (mRow == 63) mPhase = 2;
                else mRow++;
            end
        end else mPhase = 0;
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("row_valid", {31'b0, rowBus.row_valid}, {31'b0, mPhase == 1});
            chk("busy", {31'b0, busy}, {31'b0, mPhase != 0});
            chk("done", {31'b0, done}, {31'b0, mPhase == 2});
            chk("code_err", {31'b0, code_err}, {31'b0, mErr});
            if (mPhase == 1) begin
                chk("row_addr", {26'b0, rowBus.row_addr}, mRow);
                chk("row_data", {8'b0, rowBus.row_data}, {8'b0, expRow(mNote, mLen, mRow)});
            end
            if (rowBus.row_valid) cap[rowBus.row_addr] = rowBus.row_data;
            if (done) doneCnt++;
        end
    end

    // mode 0: ready high, 1: random ready + start spam, 2: stall on row 5, 3: start at row 30 then reset at row 40
    task automatic frame(input logic [15:0] n, input logic [15:0] l, input int mode);
        int cyc;
        int doneAt;
        int stall;
        @(negedge clk);
        note_code = n;
        length_code = l;
        start = 1'b1;
        rowBus.row_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        start = 1'b0;
        note_code = 16'($urandom);
        length_code = 16'($urandom);
        cyc = 1;
        doneAt = -1;
        stall = 0;
        while (busy && cyc < 1000) begin
            if (done) doneAt = cyc;
            if (mode == 1) begin
                rowBus.row_ready = 1'($urandom_range(0, 1));
                start = $urandom_range(0, 3) == 0;
            end else if (mode == 2) begin
                if (rowBus.row_valid && rowBus.row_addr == 6'd5 && stall < 3) begin
                    rowBus.row_ready = stall == 2;
                    stall++;
                end else rowBus.row_ready = 1'b1;
            end else if (mode == 3) begin
                start = rowBus.row_valid && rowBus.row_addr == 6'd30;
                if (rowBus.row_valid && rowBus.row_addr == 6'd40) begin
                    start = 1'b0;
                    #2 rst = 1'b0;
                    #1;
                    chk("rst_valid", {31'b0, rowBus.row_valid}, 32'd0);
                    chk("rst_data", {8'b0, rowBus.row_data}, 32'd0);
                    chk("rst_addr", {26'b0, rowBus.row_addr}, 32'd0);
                    chk("rst_busy", {31'b0, busy}, 32'd0);
                    chk("rst_done", {31'b0, done}, 32'd0);
                    chk("rst_err", {31'b0, code_err}, 32'd0);
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b1;
                    break;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (cyc >= 1000) chk("frame_timeout", 32'(cyc), 32'd0);
        if (mode == 0) chk("done_cycle", doneAt, 32'd65);
        if (mode == 2) chk("row5_stall", 32'(stall), 32'd3);
    endtask

    initial begin
        int d0;
        logic [15:0] nList [8];
        logic [15:0] lList [3];
        nList = '{16'h000A, 16'h000B, 16'h000C, 16'h000D, 16'h000E, 16'h000F, 16'h0001, 16'h0005};
        lList = '{16'h0001, 16'h0010, 16'h0011};
        rowBus.row_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_valid", {31'b0, rowBus.row_valid}, 32'd0);
        chk("reset_data", {8'b0, rowBus.row_data}, 32'd0);
        chk("reset_addr", {26'b0, rowBus.row_addr}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_err", {31'b0, code_err}, 32'd0);
        chk("model_c16", {8'b0, expRow(16'h000C, 16'h0001, 16)}, 32'h001800);
        chk("model_c17", {8'b0, expRow(16'h000C, 16'h0001, 17)}, 32'h003C00);
        chk("model_c24", {8'b0, expRow(16'h000C, 16'h0001, 24)}, 32'h004000);
        chk("model_1_49", {8'b0, expRow(16'h0001, 16'h0010, 49)}, 32'h002400);
        chk("model_bad", {8'b0, expRow(16'h0005, 16'h0001, 0)}, 32'h000000);
        rst = 1'b1;

        frame(16'h000C, 16'h0001, 0);
        chk("c_row16", {8'b0, cap[16]}, 32'h001800);
        chk("c_row17", {8'b0, cap[17]}, 32'h003C00);
        chk("c_row23", {8'b0, cap[23]}, 32'h001800);
        chk("c_row24", {8'b0, cap[24]}, 32'h004000);
        chk("c_row31", {8'b0, cap[31]}, 32'h004000);
        chk("c_row32", {8'b0, cap[32]}, 32'h000000);

        frame(16'h0001, 16'h0010, 0);
        chk("l_row48", {8'b0, cap[48]}, 32'h001800);
        chk("l_row50", {8'b0, cap[50]}, 32'h002400);
        chk("l_row55", {8'b0, cap[55]}, 32'h001800);
        chk("l_row56", {8'b0, cap[56]}, 32'h000000);
        chk("l_err", {31'b0, code_err}, 32'd0);

        d0 = doneCnt;
        frame(16'h0005, 16'h0001, 0);
        chk("bad_err", {31'b0, code_err}, 32'd1);
        chk("bad_row0", {8'b0, cap[0]}, 32'h000000);
        chk("bad_done_cnt", 32'(doneCnt - d0), 32'd1);

        frame(16'h000D, 16'h0001, 2);

        d0 = doneCnt;
        frame(16'h000E, 16'h0001, 3);
        chk("abort_no_done", 32'(doneCnt - d0), 32'd0);
        frame(16'h000F, 16'h0001, 0);

        frame(16'h000A, 16'h0001, 0);
`ifdef RENDER_LEDGER_EN
        chk("ledger_row3", {8'b0, cap[3]}, 32'h00FF00);
`else
        chk("ledger_row3", {8'b0, cap[3]}, 32'h003C00);
`endif

        repeat (25) begin
            frame(($urandom_range(0, 9) == 0) ? 16'($urandom) : nList[$urandom_range(0, 7)],
                  lList[$urandom_range(0, 2)], 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end
endmodule
